// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared ALU types: data width, opcode enum and the command
//               record used by the ALU issue queue. The response buffer depth
//               is fixed here because the issue credit rule assumes exactly
//               one register stage of ALU latency plus two buffered results.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int RSP_DEPTH = 2;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  // Tag is appended by the user of this record, so its width stays local.
  typedef struct packed {
    alu_op_t op;
    data_t   a;
    data_t   b;
  } alu_cmd_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Generic synchronous FIFO with registered storage. Pointers
//               carry one extra MSB so full and empty are told apart by a
//               pointer compare; occupancy is the pointer difference.
//               Push is ignored when full (even if a pop happens the same
//               cycle) and pop is ignored when empty. No write-to-read bypass:
//               data pushed into an empty FIFO reaches the head next cycle.
// Ports       : clk, rst        clock, asynchronous active-high reset
//               push_i          write request (dropped when full)
//               wr_data_i       write data
//               pop_i           read request (dropped when empty)
//               rd_data_o       current head entry
//               count_o         occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Same index bits with different wrap bits means the writer has lapped.
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_push  = push_i && !w_full;
  assign w_pop   = pop_i && !w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (w_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = wr_ptr_q - rd_ptr_q;

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : In-order command feeder for the clocked ALU. Commands are
//               queued in a FIFO, issued to the ALU inputs, and the ALU's
//               registered result is captured one cycle later into a 2-entry
//               response buffer. A command is only issued when a response
//               slot is guaranteed for it, so no result is ever dropped.
// Ports       : clk, rst                    clock, async active-high reset
//               cmd_valid/cmd_ready         command handshake
//               cmd_op/cmd_a/cmd_b/cmd_tag  command payload
//               alu_opcode/alu_a/alu_b      drive to ALU (0 when queue empty)
//               alu_out/alu_zero/alu_negative  registered ALU result
//               rsp_valid/rsp_ready         response handshake
//               rsp_data/rsp_zero/rsp_negative/rsp_tag  response payload
//               cmd_count                   command FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  alu_op_t                 cmd_op,
  input  logic [DATA_W-1:0]       cmd_a,
  input  logic [DATA_W-1:0]       cmd_b,
  input  logic [TAG_W-1:0]        cmd_tag,
  output alu_op_t                 alu_opcode,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_out,
  input  logic                    alu_zero,
  input  logic                    alu_negative,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_zero,
  output logic                    rsp_negative,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic [$clog2(DEPTH):0]  cmd_count
);

  localparam int CNT_W     = $clog2(DEPTH) + 1;
  localparam int RSP_CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int USED_W    = RSP_CNT_W + 1;

  typedef struct packed {
    alu_cmd_t         cmd;
    logic [TAG_W-1:0] tag;
  } cmd_entry_t;

  typedef struct packed {
    data_t            data;
    logic             zero;
    logic             negative;
    logic [TAG_W-1:0] tag;
  } rsp_entry_t;

  cmd_entry_t           w_cmd_in;
  cmd_entry_t           w_cmd_head;
  logic [CNT_W-1:0]     w_cmd_cnt;
  logic                 w_cmd_full;
  logic                 w_cmd_empty;
  logic                 w_cmd_push;
  logic                 w_issue;

  rsp_entry_t           w_rsp_in;
  rsp_entry_t           w_rsp_head;
  logic [RSP_CNT_W-1:0] w_rsp_cnt;
  logic                 w_rsp_empty;
  logic                 w_rsp_pop;
  logic [USED_W-1:0]    w_credit_used;

  logic                 inflight_q, inflight_d;
  logic [TAG_W-1:0]     inflight_tag_q, inflight_tag_d;

  // --------------------------------------------------------------------------
  // Command queue
  // --------------------------------------------------------------------------
  always_comb begin
    w_cmd_in         = '0;
    w_cmd_in.cmd.op  = cmd_op;
    w_cmd_in.cmd.a   = cmd_a;
    w_cmd_in.cmd.b   = cmd_b;
    w_cmd_in.tag     = cmd_tag;
  end

  assign w_cmd_full  = (w_cmd_cnt == CNT_W'(DEPTH));
  assign w_cmd_empty = (w_cmd_cnt == '0);
  // Held low during reset so nothing is accepted while state is being cleared.
  assign cmd_ready   = !w_cmd_full && !rst;
  assign w_cmd_push  = cmd_valid && cmd_ready;
  assign cmd_count   = w_cmd_cnt;

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_entry_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (w_cmd_push),
    .wr_data_i (w_cmd_in),
    .pop_i     (w_issue),
    .rd_data_o (w_cmd_head),
    .count_o   (w_cmd_cnt)
  );

  // --------------------------------------------------------------------------
  // ALU drive: head of queue, or ADD 0+0 when idle (result is never captured)
  // --------------------------------------------------------------------------
  always_comb begin
    alu_opcode = ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;
    if (!w_cmd_empty) begin
      alu_opcode = w_cmd_head.cmd.op;
      alu_a      = w_cmd_head.cmd.a;
      alu_b      = w_cmd_head.cmd.b;
    end
  end

  // --------------------------------------------------------------------------
  // Issue credit: every buffered or in-flight result owns a response slot.
  // A slot freed by this cycle's pop can be reused by this cycle's issue,
  // which is what allows one response per cycle in steady state.
  // --------------------------------------------------------------------------
  assign w_rsp_pop     = rsp_valid && rsp_ready;
  assign w_credit_used = USED_W'(w_rsp_cnt) + USED_W'(inflight_q) - USED_W'(w_rsp_pop);
  assign w_issue       = !w_cmd_empty && (w_credit_used < USED_W'(RSP_DEPTH));

  always_comb begin
    inflight_d     = w_issue;
    inflight_tag_d = inflight_tag_q;
    if (w_issue) begin
      inflight_tag_d = w_cmd_head.tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response buffer: the ALU result is valid during the cycle after issue,
  // which is exactly when inflight_q is set.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rsp_in          = '0;
    w_rsp_in.data     = alu_out;
    w_rsp_in.zero     = alu_zero;
    w_rsp_in.negative = alu_negative;
    w_rsp_in.tag      = inflight_tag_q;
  end

  alu_cmd_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (inflight_q),
    .wr_data_i (w_rsp_in),
    .pop_i     (w_rsp_pop),
    .rd_data_o (w_rsp_head),
    .count_o   (w_rsp_cnt)
  );

  assign w_rsp_empty = (w_rsp_cnt == '0);
  assign rsp_valid   = !w_rsp_empty;

  // Payload is forced to zero when no response is present so stale buffer
  // contents never appear on the port.
  always_comb begin
    rsp_data     = '0;
    rsp_zero     = 1'b0;
    rsp_negative = 1'b0;
    rsp_tag      = '0;
    if (!w_rsp_empty) begin
      rsp_data     = w_rsp_head.data;
      rsp_zero     = w_rsp_head.zero;
      rsp_negative = w_rsp_head.negative;
      rsp_tag      = w_rsp_head.tag;
    end
  end

endmodule : alu_issue_queue
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_queue
// Description : Self-checking bench for alu_issue_queue. Includes a clocked
//               ALU model, a response scoreboard fed from accepted commands,
//               directed vectors and multi-cycle sequences, and a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  alu_op_t                cmd_op;
  data_t                  cmd_a;
  data_t                  cmd_b;
  logic [TAG_W-1:0]       cmd_tag;
  alu_op_t                alu_opcode;
  data_t                  alu_a;
  data_t                  alu_b;
  data_t                  alu_out;
  logic                   alu_zero;
  logic                   alu_negative;
  logic                   rsp_valid;
  logic                   rsp_ready;
  data_t                  rsp_data;
  logic                   rsp_zero;
  logic                   rsp_negative;
  logic [TAG_W-1:0]       rsp_tag;
  logic [$clog2(DEPTH):0] cmd_count;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_tag      (cmd_tag),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .rsp_tag      (rsp_tag),
    .cmd_count    (cmd_count)
  );

  always #5 clk = ~clk;

  function automatic data_t alu_ref(input alu_op_t op, input data_t a, input data_t b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a | b;
    endcase
  endfunction

  // Clocked ALU: one register stage between operands and result.
  always @(posedge clk) alu_out <= alu_ref(alu_opcode, alu_a, alu_b);
  assign alu_zero     = (alu_out == '0);
  assign alu_negative = alu_out[DATA_W-1];

  typedef struct packed {
    data_t            d;
    logic             z;
    logic             n;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  function automatic rsp_t mk_rsp(input alu_op_t op, input data_t a, input data_t b,
                                  input logic [TAG_W-1:0] tag);
    rsp_t  r;
    data_t v;
    v     = alu_ref(op, a, b);
    r.d   = v;
    r.z   = (v == '0);
    r.n   = v[DATA_W-1];
    r.tag = tag;
    return r;
  endfunction

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   n_pop   = 0;
  int   cyc     = 0;
  rsp_t exp_q[$];
  int   pop_cyc[$];
  rsp_t prev;
  logic hold = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
      chk("rsp_valid_in_reset", 64'(rsp_valid), 64'(0));
    end else begin
      chk("cmd_ready_vs_count", 64'(cmd_ready), 64'(cmd_count != ($clog2(DEPTH)+1)'(DEPTH)));
      if (hold)
        chk("rsp_hold", 64'({rsp_valid, rsp_data, rsp_zero, rsp_negative, rsp_tag}),
            64'({1'b1, prev}));
      if (rsp_valid && rsp_ready) begin
        n_pop++;
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got tag %0d expected no response", rsp_tag);
        end else begin
          chk("rsp_order", 64'({rsp_data, rsp_zero, rsp_negative, rsp_tag}),
              64'(exp_q.pop_front()));
        end
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        exp_q.push_back(mk_rsp(cmd_op, cmd_a, cmd_b, cmd_tag));
      end
      hold = rsp_valid && !rsp_ready;
      prev = {rsp_data, rsp_zero, rsp_negative, rsp_tag};
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents one command and returns just after the edge that accepted it.
  task automatic send(input alu_op_t op, input data_t a, input data_t b,
                      input logic [TAG_W-1:0] tag);
    int g;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 50) begin
      step();
      g++;
    end
    if (g == 50) chk("send_timeout", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (n_pop != n_acc && g < 100) begin
      step();
      g++;
    end
    chk(nm, 64'(n_pop), 64'(n_acc));
  endtask

  typedef struct {
    alu_op_t          op;
    data_t            a;
    data_t            b;
    logic [TAG_W-1:0] tag;
    data_t            exp_d;
    logic             exp_z;
    logic             exp_n;
  } vec_t;

  vec_t vt[6];

  initial begin
    int k;
    int acc;
    int rtag;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = ALU_ADD;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;

    vt[0] = '{ALU_ADD, 32'd5,          32'd7,          4'd3,  32'd12,         1'b0, 1'b0};
    vt[1] = '{ALU_SUB, 32'd4,          32'd4,          4'd1,  32'd0,          1'b1, 1'b0};
    vt[2] = '{ALU_SUB, 32'd0,          32'd1,          4'd2,  32'hFFFF_FFFF,  1'b0, 1'b1};
    vt[3] = '{ALU_AND, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd9,  32'h00F0_00F0,  1'b0, 1'b0};
    vt[4] = '{ALU_OR,  32'h8000_0000,  32'h0000_0001,  4'd14, 32'h8000_0001,  1'b0, 1'b1};
    vt[5] = '{ALU_ADD, 32'hFFFF_FFFF,  32'h0000_0001,  4'd15, 32'h0000_0000,  1'b1, 1'b0};

    // ---- reset state ----
    step();
    step();
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("reset_cmd_count", 64'(cmd_count), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_data",  64'({rsp_data, rsp_zero, rsp_negative, rsp_tag}), 64'(0));
    chk("reset_alu_drive", 64'({alu_opcode, alu_a, alu_b}), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));

    // ---- isolated vectors with latency ----
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
      k = 0;
      while (!rsp_valid && k < 10) begin
        step();
        k++;
      end
      chk("vec_latency",  64'(k), 64'(2));
      chk("vec_data",     64'(rsp_data), 64'(vt[i].exp_d));
      chk("vec_flags",    64'({rsp_zero, rsp_negative}), 64'({vt[i].exp_z, vt[i].exp_n}));
      chk("vec_tag",      64'(rsp_tag), 64'(vt[i].tag));
      step();
      chk("vec_rsp_gone", 64'(rsp_valid), 64'(0));
    end

    // ---- back-to-back stream, one response per cycle ----
    pop_cyc.delete();
    for (int t = 0; t < 16; t++) send(ALU_ADD, data_t'(t), 32'd100, TAG_W'(t));
    drain("stream_drain");
    chk("stream_count", 64'(pop_cyc.size()), 64'(16));
    if (pop_cyc.size() == 16)
      chk("stream_consecutive", 64'(pop_cyc[15] - pop_cyc[0]), 64'(15));

    // ---- backpressure fill ----
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      cmd_op  = ALU_SUB;
      cmd_a   = data_t'(1000 + acc);
      cmd_b   = data_t'(acc * 3);
      cmd_tag = TAG_W'(acc);
      if (cmd_ready) acc++;
      step();
    end
    chk("bp_accepted",  64'(acc), 64'(6));
    chk("bp_count",     64'(cmd_count), 64'(DEPTH));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    repeat (3) step();

    // ---- push into full queue on the same cycle issue pops ----
    cmd_op    = ALU_OR;
    cmd_a     = 32'h0000_0600;
    cmd_b     = 32'h0000_0006;
    cmd_tag   = TAG_W'(6);
    rsp_ready = 1'b1;
    chk("full_pop_ready", 64'(cmd_ready), 64'(0));
    step();
    chk("full_pop_count", 64'(cmd_count), 64'(DEPTH - 1));
    chk("full_pop_ready_after", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 1'b0;
    drain("bp_drain");
    chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // ---- reset mid-stream ----
    rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) send(ALU_ADD, data_t'(t), 32'd1, TAG_W'(t));
    rsp_ready = 1'b1;
    send(ALU_ADD, 32'd50, 32'd1, TAG_W'(5));
    rsp_ready = 1'b0;
    chk("pre_reset_count", 64'(cmd_count), 64'(3));
    chk("pre_reset_rsp",   64'(rsp_valid), 64'(1));
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_count",     64'(cmd_count), 64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    step();
    step();
    rst   = 1'b0;
    n_acc = 0;
    n_pop = 0;
    rsp_ready = 1'b1;
    repeat (10) step();
    chk("no_stale_rsp", 64'(n_pop), 64'(0));
    send(ALU_SUB, 32'd9, 32'd2, TAG_W'(7));
    drain("post_reset_drain");

    // ---- random traffic against the scoreboard ----
    rtag = 0;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = (($urandom % 4) != 0);
      cmd_op    = alu_op_t'($urandom % 4);
      cmd_a     = (($urandom % 3) == 0) ? data_t'($urandom % 4) : data_t'($urandom);
      cmd_b     = (($urandom % 3) == 0) ? data_t'($urandom % 4) : data_t'($urandom);
      cmd_tag   = TAG_W'(rtag);
      rsp_ready = (($urandom % 10) < 7);
      if (cmd_valid && cmd_ready) rtag++;
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("random_drain");
    chk("random_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_issue_queue
`default_nettype wire
